// File: rtl/core_control_hazard_if.sv
// Decode-to-hazard-controller issue bus: instruction register usage in, pipeline control out.
interface core_control_hazard_if #(
    parameter int NUM_REGS = 16,
    parameter int LAT_W    = 2
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                halt;
    logic                issue_valid;
    logic [IDX_W-1:0]    rs_a;
    logic [IDX_W-1:0]    rs_b;
    logic                rs_a_used;
    logic                rs_b_used;
    logic [IDX_W-1:0]    rd;
    logic                rd_write;
    logic [LAT_W-1:0]    wr_latency;
    logic                reads_flags;
    logic                writes_flags;
    logic [LAT_W-1:0]    flags_latency;
    logic                stall;
    logic                bubble;
    logic                next_bubble;
    logic                halted;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output halt, issue_valid, rs_a, rs_b, rs_a_used, rs_b_used, rd, rd_write,
               wr_latency, reads_flags, writes_flags, flags_latency,
        input  stall, bubble, next_bubble, halted, pending
    );

    modport slave (
        input  halt, issue_valid, rs_a, rs_b, rs_a_used, rs_b_used, rd, rd_write,
               wr_latency, reads_flags, writes_flags, flags_latency,
        output stall, bubble, next_bubble, halted, pending
    );
endinterface

// File: rtl/core_control_hazard.sv
// Stall/bubble controller: register and flags write scoreboard plus PC-redirect drain.
// Define CORE_HAZARD_FWD_EN when a bypass network forwards results due within one cycle.
module core_control_hazard #(
    parameter int NUM_REGS   = 16,
    parameter int LAT_W      = 2,
    parameter int PC_REG     = 15,
    parameter int PC_BUBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_control_hazard_if.slave bus
);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int DRAIN_W = $clog2(PC_BUBBLES + 1);

    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic [LAT_W-1:0]    flags_cnt_q, flags_cnt_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                bubble_q, bubble_d;

    logic                hazard;
    logic                next_bubble;
    logic                stall;
    logic                accept;
    logic [NUM_REGS-1:0] pending;
    logic                rd_is_pc;

    // A source result is only a hazard while it cannot be obtained from the bypass.
    function automatic logic srcpend(input logic [LAT_W-1:0] c);
`ifdef CORE_HAZARD_FWD_EN
        return c > LAT_W'(1);
`else
        return c != '0;
`endif
    endfunction

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pending[i] = cnt_q[i] != '0;
        end
    end

    assign rd_is_pc = bus.rd == IDX_W'(PC_REG);

    always_comb begin
        hazard = bus.issue_valid && (
                 (bus.rs_a_used && bus.rs_a != IDX_W'(PC_REG) && srcpend(cnt_q[bus.rs_a])) ||
                 (bus.rs_b_used && bus.rs_b != IDX_W'(PC_REG) && srcpend(cnt_q[bus.rs_b])) ||
                 (bus.rd_write && cnt_q[bus.rd] != '0) ||
                 (bus.reads_flags && srcpend(flags_cnt_q)) ||
                 (bus.writes_flags && flags_cnt_q != '0));
        next_bubble = hazard || drain_q != '0;
        stall       = !bus.issue_valid || next_bubble || bus.halt;
        accept      = bus.issue_valid && !stall;
    end

    // Accepted writes load their latency over the free-running decrement.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
            if (accept && bus.rd_write && !rd_is_pc && bus.rd == IDX_W'(i)) begin
                cnt_d[i] = bus.wr_latency;
            end
        end

        flags_cnt_d = (flags_cnt_q != '0) ? flags_cnt_q - LAT_W'(1) : '0;
        if (accept && bus.writes_flags) begin
            flags_cnt_d = bus.flags_latency;
        end

        drain_d = (drain_q != '0) ? drain_q - DRAIN_W'(1) : '0;
        if (accept && bus.rd_write && rd_is_pc) begin
            drain_d = DRAIN_W'(PC_BUBBLES);
        end

        bubble_d = bus.issue_valid && next_bubble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            flags_cnt_q <= '0;
            drain_q     <= '0;
            bubble_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            flags_cnt_q <= flags_cnt_d;
            drain_q     <= drain_d;
            bubble_q    <= bubble_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.next_bubble = next_bubble;
    assign bus.bubble      = bubble_q;
    assign bus.pending     = pending;
    assign bus.halted      = bus.halt && bus.issue_valid && !next_bubble &&
                             pending == '0 && flags_cnt_q == '0;
endmodule

// File: tb/tb_core_control_hazard.sv
// Directed bench for core_control_hazard: cycle table plus multi-cycle corner sequences.
module tb_core_control_hazard;
`ifdef CORE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    core_control_hazard_if #(.NUM_REGS(16), .LAT_W(2)) bus ();

    core_control_hazard #(
        .NUM_REGS  (16),
        .LAT_W     (2),
        .PC_REG    (15),
        .PC_BUBBLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int halt; int iv;
        int ra; int rau; int rb; int rbu;
        int rd; int rdw; int wl;
        int rf; int wf; int fl;
        int e_stall; int e_bub; int e_nb; int e_halted; int e_pend;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        bus.halt = 1'b0; bus.issue_valid = 1'b0;
        bus.rs_a = '0; bus.rs_a_used = 1'b0; bus.rs_b = '0; bus.rs_b_used = 1'b0;
        bus.rd = '0; bus.rd_write = 1'b0; bus.wr_latency = '0;
        bus.reads_flags = 1'b0; bus.writes_flags = 1'b0; bus.flags_latency = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.halt = 1'(v.halt); bus.issue_valid = 1'(v.iv);
        bus.rs_a = 4'(v.ra); bus.rs_a_used = 1'(v.rau);
        bus.rs_b = 4'(v.rb); bus.rs_b_used = 1'(v.rbu);
        bus.rd = 4'(v.rd); bus.rd_write = 1'(v.rdw); bus.wr_latency = 2'(v.wl);
        bus.reads_flags = 1'(v.rf); bus.writes_flags = 1'(v.wf);
        bus.flags_latency = 2'(v.fl);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        // halt iv  ra rau rb rbu rd rdw wl  rf wf fl  stall bub nb halted pend
        tbl = '{
            '{0,1-1, 0,0, 0,0,  0,0, 0,  0,0,0,  1,0,0,0, 'h0000},
            '{0,1,   0,0, 0,0,  2,1, 3,  0,0,0,  0,0,0,0, 'h0000},
            '{0,1,   2,1, 0,0,  0,0, 0,  0,0,0,  1,0,1,0, 'h0004},
            '{0,1,   0,0, 2,1,  0,0, 0,  0,0,0,  1,1,1,0, 'h0004},
            '{0,1,   2,0, 2,0,  2,1, 1,  0,0,0,  1,1,1,0, 'h0004},
            '{0,1,   2,0, 2,0,  2,1, 1,  0,0,0,  0,1,0,0, 'h0000},
            '{0,1,  15,1, 0,0,  4,1, 0,  0,0,0,  0,0,0,0, 'h0004},
            '{0,1,   4,1, 4,1,  4,1, 2,  0,0,0,  0,0,0,0, 'h0000},
            '{0,1,   4,1, 4,1,  4,1, 0,  0,0,0,  1,0,1,0, 'h0010},
            '{0,0,   0,0, 0,0,  0,0, 0,  0,0,0,  1,1,0,0, 'h0010},
            '{0,1,   0,0, 0,0, 15,1, 0,  0,0,0,  0,0,0,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,0,0,  1,0,1,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,0,0,  1,1,1,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,0,0,  0,1,0,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,1,2,  0,0,0,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  1,0,0,  1,0,1,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,1,1,  1,1,1,0, 'h0000},
            '{0,1,   0,0, 0,0,  0,0, 0,  0,1,1,  0,1,0,0, 'h0000},
            '{0,0,   0,0, 0,0,  0,0, 0,  0,0,0,  1,0,0,0, 'h0000},
            '{1,1,   0,0, 0,0,  0,0, 0,  0,0,0,  1,0,0,1, 'h0000},
            '{1,0,   0,0, 0,0,  0,0, 0,  0,0,0,  1,0,0,0, 'h0000}
        };

        // Reset state
        clr();
        rst_n = 1'b0;
        #2;
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_next_bubble", 32'(bus.next_bubble), 32'd0);
        chk("rst_bubble", 32'(bus.bubble), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Cycle table
        for (int r = 0; r < 21; r++) begin
            apply(tbl[r]);
            #3;
            chk($sformatf("row%0d_stall", r), 32'(bus.stall), 32'(tbl[r].e_stall));
            chk($sformatf("row%0d_bubble", r), 32'(bus.bubble), 32'(tbl[r].e_bub));
            chk($sformatf("row%0d_next_bubble", r), 32'(bus.next_bubble), 32'(tbl[r].e_nb));
            chk($sformatf("row%0d_halted", r), 32'(bus.halted), 32'(tbl[r].e_halted));
            chk($sformatf("row%0d_pending", r), 32'(bus.pending), 32'(tbl[r].e_pend));
            tick();
        end
        clr();
        tick();
        tick();

        // RAW on r3 with latency 2
        begin
            int exp_stall [3];
            int exp_nb    [3];
            int exp_bub   [3];
            exp_stall = FWD ? '{1, 0, 0} : '{1, 1, 0};
            exp_nb    = FWD ? '{1, 0, 0} : '{1, 1, 0};
            exp_bub   = FWD ? '{0, 1, 0} : '{0, 1, 1};
            bus.issue_valid = 1'b1; bus.rd = 4'd3; bus.rd_write = 1'b1; bus.wr_latency = 2'd2;
            #3;
            chk("raw_c0_stall", 32'(bus.stall), 32'd0);
            tick();
            clr();
            bus.issue_valid = 1'b1; bus.rs_a = 4'd3; bus.rs_a_used = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #3;
                chk($sformatf("raw_c%0d_stall", k + 1), 32'(bus.stall), 32'(exp_stall[k]));
                chk($sformatf("raw_c%0d_next_bubble", k + 1), 32'(bus.next_bubble), 32'(exp_nb[k]));
                chk($sformatf("raw_c%0d_bubble", k + 1), 32'(bus.bubble), 32'(exp_bub[k]));
                tick();
            end
            clr();
            tick();
            tick();
        end

        // Flags written with latency 1, then read
        bus.issue_valid = 1'b1; bus.writes_flags = 1'b1; bus.flags_latency = 2'd1;
        #3;
        chk("flags_c0_stall", 32'(bus.stall), 32'd0);
        tick();
        clr();
        bus.issue_valid = 1'b1; bus.reads_flags = 1'b1;
        #3;
        chk("flags_c1_stall", 32'(bus.stall), FWD ? 32'd0 : 32'd1);
        tick();
        #3;
        chk("flags_c2_stall", 32'(bus.stall), 32'd0);
        tick();
        clr();
        tick();
        tick();

        // Halt while r5 is in flight for 3 cycles
        bus.issue_valid = 1'b1; bus.rd = 4'd5; bus.rd_write = 1'b1; bus.wr_latency = 2'd3;
        #3;
        chk("halt_c0_stall", 32'(bus.stall), 32'd0);
        tick();
        clr();
        bus.halt = 1'b1; bus.issue_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("halt_c%0d_halted", k + 1), 32'(bus.halted), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("halt_c%0d_stall", k + 1), 32'(bus.stall), 32'd1);
            chk($sformatf("halt_c%0d_pending", k + 1), 32'(bus.pending), (k < 3) ? 32'h20 : 32'h0);
            tick();
        end
        clr();
        tick();

        // Reset in the middle of an in-flight write and a bubble
        bus.issue_valid = 1'b1; bus.rd = 4'd3; bus.rd_write = 1'b1; bus.wr_latency = 2'd2;
        tick();
        clr();
        bus.issue_valid = 1'b1; bus.rs_a = 4'd3; bus.rs_a_used = 1'b1;
        #3;
        chk("mid_rst_pre_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("mid_rst_pre_bubble", 32'(bus.bubble), 32'd1);
        chk("mid_rst_pre_pending", 32'(bus.pending), 32'h8);
        clr();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", 32'(bus.pending), 32'd0);
        chk("mid_rst_bubble", 32'(bus.bubble), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        bus.issue_valid = 1'b1; bus.rs_a = 4'd3; bus.rs_a_used = 1'b1;
        #3;
        chk("post_rst_accept_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_bubble", 32'(bus.bubble), 32'd0);
        tick();
        clr();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
